cordic_vectoring: RTL and testbench
===================================

Name: cordic_vectoring

Overview:
- Iterative (one micro-rotation per clock) CORDIC in vectoring mode; the inverse of the existing rotation-mode block.
- Takes a Cartesian vector (x_in, y_in) and returns its magnitude and angle in degrees.
- Fixed-point formats match the rotation block: coordinates Q3.16, angles Q15.4 degrees.
- Sits after coordinate-producing logic, or in loop-back with the rotation block for round-trip checks.

Parameters:
- DATA_W, 20, coordinate width, signed Q3.16.
- ANG_W, 20, angle width, signed Q15.4 degrees.
- N_ITER, 10, micro-rotations (legal 4..12).
- GUARD, 2, extra MSBs on internal x/y datapath.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  DATA_W  signed x, Q3.16.
- y_in  in  DATA_W  signed y, Q3.16.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when results update.
- mag_out  out  DATA_W+1  magnitude, Q4.16, always >= 0.
- ang_out  out  ANG_W  angle in (-180, 180] degrees, Q15.4.

Behaviour:
- Reset (clk edge with rst==0): state IDLE; busy=0, done=0, mag_out=0, ang_out=0; internal registers cleared. Reset mid-conversion aborts it; no done is issued.
- States and transitions:
  - IDLE: start=1 latches inputs, does pre-rotation, goes to ITER (i=0).
  - ITER: one micro-rotation per cycle; after i=N_ITER-1 goes to SCALE.
  - SCALE: writes outputs, done=1, returns to IDLE.
- Latency: done asserts N_ITER+1 edges after the accepting edge (11 for default). busy=1 from the accepting edge until the edge that raises done.
- start while busy is ignored, not queued. start in the same cycle done=1 is accepted (back-to-back, no gap cycle).
- mag_out/ang_out hold their values until the next done or reset.
- Pre-rotation at accept (internal x,y are DATA_W+GUARD bits, sign-extended):
  - x_in>=0: x0=x, y0=y, z0=0.
  - x_in<0, y_in>=0: x0=y, y0=-x, z0=+90.0 (1440).
  - x_in<0, y_in<0: x0=-y, y0=x, z0=-90.0 (-1440).
- Micro-rotation i:
  - y>=0: x+=y>>>i; y-=x>>>i; z+=atan[i].
  - else: x-=y>>>i; y+=x>>>i; z-=atan[i].
  - Updates use previous-cycle values (simultaneous); shifts are arithmetic; no rounding.
- atan table, degrees Q15.4: 720, 425, 225, 114, 57, 29, 14, 7, 4, 2, 1, 0.
- SCALE: gain compensation by shift-add, mag = x - x>>>2 ... evaluated as x>>>1 + x>>>3 - x>>>6 - x>>>9 - x>>>13 (≈0.60730). Result is truncated to DATA_W+1 bits; it cannot overflow for in-range inputs.
- ang_out = z. If z == -180.0 (-2880), output +180.0 (2880).
- Zero vector: x_in=y_in=0 is flagged at accept. Result is mag_out=0, ang_out=0, with normal latency.
- Full-scale inputs (-8.0) are legal; GUARD bits absorb the growth (max ≈ 8√2·1.647).

Decomposition:
- Shared package cordic_pkg, used by both rotation and vectoring blocks:
  - Format widths and fractional-bit constants.
  - atan LUT constant array (12 entries, Q15.4).
  - Gain-compensation shift constants.
  - ±90/180 degree constants.
  - State enum (IDLE, ITER, SCALE).
- Sub-module cordic_atan_rom: combinational index → atan[i] lookup, shared with the rotation block.
- Datapath and FSM stay in cordic_vectoring.

Test Plan:
- Axis cases:
  - x=1.0 (0x10000), y=0 → ang_out 0 ±8 LSB, mag_out 65536 ±0.2%.
  - x=0, y=1.0 → ang_out 1440 ±8.
  - x=-1.0, y=0 → ang_out 2880 ±8, never -2880.
- Diagonal cases:
  - x=y=1.0 → ang_out 720 ±8, mag_out 92682 ±0.2%.
  - x=y=-1.0 → ang_out -2160 ±8.
  - x=3.0, y=-4.0 → mag_out 327680 ±0.2%, ang_out -850 (-53.13°) ±8.
- Zero vector: x=y=0 → mag_out 0, ang_out 0; done exactly 11 cycles after start.
- Handshake:
  - start held high continuously → accepts only in IDLE, done every 11 cycles, busy low only on the cycle done is high.
  - start pulses mid-conversion are ignored.
- Reset mid-op: rst=0 at iteration 5 → next cycle busy=0, outputs 0; no done pulse; next start converts correctly.
- Round-trip: 500 random angles through the rotation block, then into cordic_vectoring → ang_out matches input ±16 LSB, mag_out ≈ 1.0 ±0.5%.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared fixed-point formats, arctangent table and constants for the CORDIC
// rotation and vectoring blocks.
package cordic_pkg;

    localparam int CORDIC_DATA_W = 20;   // coordinates, signed Q3.16
    localparam int CORDIC_ANG_W  = 20;   // angles, signed Q15.4 degrees
    localparam int COORD_FRAC_W  = 16;
    localparam int ANG_FRAC_W    = 4;

    localparam int ATAN_N = 12;
    localparam logic signed [CORDIC_ANG_W-1:0] ATAN_LUT [ATAN_N] = '{
        20'sd720, 20'sd425, 20'sd225, 20'sd114, 20'sd57, 20'sd29,
        20'sd14,  20'sd7,   20'sd4,   20'sd2,   20'sd1,  20'sd0
    };

    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 (~0.60730)
    localparam int GAIN_SH_A = 1;
    localparam int GAIN_SH_B = 3;
    localparam int GAIN_SH_C = 6;
    localparam int GAIN_SH_D = 9;
    localparam int GAIN_SH_E = 13;

    localparam int ANG_90_DEG  = 1440;
    localparam int ANG_180_DEG = 2880;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SCALE = 2'd2
    } cordic_state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: atan(2^-idx) in Q15.4 degrees.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int ANG_W = CORDIC_ANG_W
) (
    input  logic [3:0]              idx,
    output logic signed [ANG_W-1:0] angle
);

    always_comb begin
        angle = '0;
        if (int'(idx) < ATAN_N) begin
            angle = ANG_W'(ATAN_LUT[idx]);
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, converts
// (x, y) into magnitude (Q4.16) and angle (Q15.4 degrees).
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int DATA_W = CORDIC_DATA_W,
    parameter int ANG_W  = CORDIC_ANG_W,
    parameter int N_ITER = 10,
    parameter int GUARD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W:0]   mag_out,
    output logic signed [ANG_W-1:0]  ang_out
);

    localparam int XW = DATA_W + GUARD;
    localparam logic signed [ANG_W-1:0] Z_P90  = ANG_W'(ANG_90_DEG);
    localparam logic signed [ANG_W-1:0] Z_M90  = ANG_W'(-ANG_90_DEG);
    localparam logic signed [ANG_W-1:0] Z_P180 = ANG_W'(ANG_180_DEG);
    localparam logic signed [ANG_W-1:0] Z_M180 = ANG_W'(-ANG_180_DEG);

    cordic_state_t           state;
    logic [3:0]              iter;
    logic signed [XW-1:0]    x;
    logic signed [XW-1:0]    y;
    logic signed [ANG_W-1:0] z;
    logic                    zero_vec;

    logic signed [XW-1:0]    x_ext;
    logic signed [XW-1:0]    y_ext;
    logic signed [XW-1:0]    x_next;
    logic signed [XW-1:0]    y_next;
    logic signed [XW-1:0]    mag_full;
    logic signed [ANG_W-1:0] atan_i;
    logic signed [ANG_W-1:0] z_next;
    logic signed [ANG_W-1:0] ang_fix;

    cordic_atan_rom #(.ANG_W(ANG_W)) u_atan_rom (
        .idx   (iter),
        .angle (atan_i)
    );

    assign x_ext = XW'(x_in);
    assign y_ext = XW'(y_in);

    // Drive y toward zero; x and y both use the previous cycle's values.
    always_comb begin
        x_next = x;
        y_next = y;
        z_next = z;
        if (!y[XW-1]) begin
            x_next = x + (y >>> iter);
            y_next = y - (x >>> iter);
            z_next = z + atan_i;
        end else begin
            x_next = x - (y >>> iter);
            y_next = y + (x >>> iter);
            z_next = z - atan_i;
        end
    end

    assign mag_full = (x >>> GAIN_SH_A) + (x >>> GAIN_SH_B) - (x >>> GAIN_SH_C)
                    - (x >>> GAIN_SH_D) - (x >>> GAIN_SH_E);
    assign ang_fix  = (z == Z_M180) ? Z_P180 : z;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            iter     <= '0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            zero_vec <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mag_out  <= '0;
            ang_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        iter     <= '0;
                        zero_vec <= (x_in == '0) && (y_in == '0);
                        state    <= ITER;
                        // Pre-rotate into the right half-plane so the
                        // micro-rotations only need to cover +/-99.9 degrees.
                        if (!x_in[DATA_W-1]) begin
                            x <= x_ext;
                            y <= y_ext;
                            z <= '0;
                        end else if (!y_in[DATA_W-1]) begin
                            x <= y_ext;
                            y <= -x_ext;
                            z <= Z_P90;
                        end else begin
                            x <= -y_ext;
                            y <= x_ext;
                            z <= Z_M90;
                        end
                    end
                end
                ITER: begin
                    x    <= x_next;
                    y    <= y_next;
                    z    <= z_next;
                    iter <= iter + 4'd1;
                    if (iter == 4'(N_ITER - 1)) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    mag_out <= zero_vec ? '0 : (DATA_W + 1)'(mag_full);
                    ang_out <= zero_vec ? '0 : ang_fix;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: fixed vector table, handshake/reset sequences,
// and random vectors checked against real-valued atan2/sqrt.
module tb_cordic_vectoring;

    localparam int  N_ITER  = 10;
    localparam int  LAT     = N_ITER + 1;
    localparam int  PERIOD  = N_ITER + 2;
    localparam int  TIMEOUT = 40;
    localparam real PI      = 3.14159265358979;

    logic               clk   = 1'b0;
    logic               rst   = 1'b0;
    logic               start = 1'b0;
    logic signed [19:0] x_in  = '0;
    logic signed [19:0] y_in  = '0;
    logic               busy;
    logic               done;
    logic signed [20:0] mag_out;
    logic signed [19:0] ang_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int x;
        int y;
        int exp_mag;
        int exp_ang;
        int mag_tol;
        int ang_tol;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    cordic_vectoring #(
        .DATA_W(20), .ANG_W(20), .N_ITER(N_ITER), .GUARD(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .busy    (busy),
        .done    (done),
        .mag_out (mag_out),
        .ang_out (ang_out)
    );

    function automatic vec_t mk(int x, int y, int m, int a, int mt, int at);
        vec_t v;
        v.x = x; v.y = y; v.exp_mag = m; v.exp_ang = a; v.mag_tol = mt; v.ang_tol = at;
        return v;
    endfunction

    // Angular distance in Q15.4 units, wrapped to the shorter way round.
    function automatic real ang_dist(real a, real b);
        real d = a - b;
        while (d > 2880.0)   d = d - 5760.0;
        while (d <= -2880.0) d = d + 5760.0;
        return (d < 0.0) ? -d : d;
    endfunction

    task automatic check_int(input string name, input int act, input int req, input int tol);
        int d = act - req;
        n_cmp++;
        if (d > tol || -d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
        end
    endtask

    task automatic check_ang(input string name, input int act, input real req, input real tol);
        n_cmp++;
        if (ang_dist(real'(act), req) > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %f (tol %f)", name, act, req, tol);
        end
    endtask

    task automatic check_real(input string name, input int act, input real req, input real tol);
        real d = real'(act) - req;
        n_cmp++;
        if (d > tol || -d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %f (tol %f)", name, act, req, tol);
        end
    endtask

    // Issue one conversion from IDLE and wait (bounded) for done.
    task automatic convert(input int x, input int y, output int m, output int a);
        int lat;
        @(negedge clk);
        x_in  = 20'(x);
        y_in  = 20'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check_int("latency", lat, LAT, 0);
        m = int'(mag_out);
        a = int'(ang_out);
    endtask

    initial begin
        int m, a, exp_q[$], ndone;
        real em, ea, th;

        vecs[0] = mk(65536, 0, 65536, 0, 131, 8);
        vecs[1] = mk(0, 65536, 65536, 1440, 131, 8);
        vecs[2] = mk(-65536, 0, 65536, 2880, 131, 8);
        vecs[3] = mk(65536, 65536, 92682, 720, 185, 8);
        vecs[4] = mk(-65536, -65536, 92682, -2160, 185, 8);
        vecs[5] = mk(196608, -262144, 327680, -850, 655, 8);
        vecs[6] = mk(0, 0, 0, 0, 0, 0);
        vecs[7] = mk(-524288, -524288, 741455, -2160, 1483, 8);
        vecs[8] = mk(524287, 0, 524287, 0, 1049, 8);

        // Reset state
        repeat (3) @(negedge clk);
        check_int("reset_busy", int'(busy), 0, 0);
        check_int("reset_done", int'(done), 0, 0);
        check_int("reset_mag", int'(mag_out), 0, 0);
        check_int("reset_ang", int'(ang_out), 0, 0);
        rst = 1'b1;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].x, vecs[i].y, m, a);
            check_int($sformatf("vec%0d_mag", i), m, vecs[i].exp_mag, vecs[i].mag_tol);
            check_int($sformatf("vec%0d_ang", i), a, vecs[i].exp_ang, vecs[i].ang_tol);
        end
        convert(-65536, 0, m, a);
        n_cmp++;
        if (a == -2880) begin
            n_err++;
            $display("FAIL neg_x_axis_wrap: got %0d, required value other than -2880", a);
        end

        // start held high: accepted back-to-back on each done cycle
        exp_q = {};
        for (int j = 0; j < 3; j++) exp_q.push_back(LAT + j * PERIOD);
        @(negedge clk);
        x_in = 20'sd65536; y_in = 20'sd0; start = 1'b1;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk);
            check_int("cont_busy", int'(busy), (k % PERIOD == LAT) ? 0 : 1, 0);
            if (done) begin
                if (exp_q.size() == 0) check_int("cont_extra_done", k, -1, 0);
                else check_int("cont_done_pos", k, exp_q.pop_front(), 0);
                check_int("cont_ang", int'(ang_out), 0, 8);
            end
        end
        start = 1'b0;
        check_int("cont_missing_done", exp_q.size(), 0, 0);
        repeat (2) @(negedge clk);
        check_int("cont_idle_busy", int'(busy), 0, 0);

        // start pulses mid-conversion are ignored
        @(negedge clk);
        x_in = 20'sd0; y_in = 20'sd65536; start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                check_int("ignore_done_pos", k, LAT, 0);
                check_ang("ignore_ang", int'(ang_out), 1440.0, 8.0);
            end
            if (k == 3 || k == 7) begin
                x_in = -20'sd65536; y_in = 20'sd0; start = 1'b1;
            end
        end
        check_int("ignore_done_count", ndone, 1, 0);

        // Reset during iteration 5 aborts without a done pulse
        @(negedge clk);
        x_in = 20'sd196608; y_in = -20'sd262144; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_int("midrst_busy", int'(busy), 0, 0);
        check_int("midrst_done", int'(done), 0, 0);
        check_int("midrst_mag", int'(mag_out), 0, 0);
        check_int("midrst_ang", int'(ang_out), 0, 0);
        rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_int("midrst_no_done", ndone, 0, 0);
        convert(196608, -262144, m, a);
        check_int("midrst_after_mag", m, 327680, 655);
        check_int("midrst_after_ang", a, -850, 8);

        // Random full-range vectors against atan2/sqrt
        for (int n = 0; n < 100; n++) begin
            int x, y;
            x  = int'($urandom_range(0, 1048575)) - 524288;
            y  = int'($urandom_range(0, 1048575)) - 524288;
            em = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
            ea = $atan2(real'(y), real'(x)) * 180.0 / PI * 16.0;
            convert(x, y, m, a);
            check_real("rand_mag", m, em, em * 0.002 + 16.0);
            if (em >= 4096.0) check_ang("rand_ang", a, ea, 8.0);
        end

        // Round trip: unit vectors at random angles
        for (int n = 0; n < 500; n++) begin
            int ang_in, x, y;
            ang_in = int'($urandom_range(0, 5759)) - 2879;
            th     = real'(ang_in) / 16.0 * PI / 180.0;
            x      = int'(65536.0 * $cos(th));
            y      = int'(65536.0 * $sin(th));
            convert(x, y, m, a);
            check_ang("rt_ang", a, real'(ang_in), 16.0);
            check_real("rt_mag", m, 65536.0, 327.68);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
